coded_lock_seq: RTL and testbench
=================================

CODED_LOCK_SEQ -- requirements
Module: coded_lock_seq

Interface
REQ-001 Parameter DIGIT_W, default 4, sets the bits per entered digit.
REQ-002 Parameter CODE_LEN, default 4, sets the number of digits in the code (2..16).
REQ-003 Parameter INIT_CODE, default 16'h1234 (width DIGIT_W*CODE_LEN), is the reset code; the most-significant digit is entered first.
REQ-004 Parameter MAX_FAIL, default 3, is the number of consecutive failed attempts that triggers lockout.
REQ-005 Parameter OPEN_CYC, default 500, sets how many cycles open stays asserted.
REQ-006 Parameter LOCKOUT_CYC, default 1000, sets the lockout duration in cycles.
REQ-007 Parameter ENTRY_TO, default 2000, sets the idle-cycle timeout during digit entry.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous and active-high.
REQ-010 digit  in  DIGIT_W  digit value, sampled when digit_vld=1.
REQ-011 digit_vld  in  1  single-cycle digit strobe.
REQ-012 enter  in  1  single-cycle submit strobe; in OPEN it means relock.
REQ-013 clr  in  1  single-cycle strobe that discards the current entry.
REQ-014 prog  in  1  single-cycle strobe that stores the buffered entry as the new code (OPEN only).
REQ-015 open  out  1  unlock indication.
REQ-016 alarm  out  1  failed-attempt indication, latched.
REQ-017 lockout  out  1  lockout active.
REQ-018 fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count.
REQ-019 code_upd  out  1  one-cycle pulse when the code is reprogrammed.
REQ-020 led1 / led2  out  1  active-low drives, led1 = ~open and led2 = ~alarm.

Function
REQ-021 The FSM SHALL have the states IDLE, ENTRY, CHECK, OPEN and LOCKOUT; all outputs SHALL be registered except led1 and led2.
REQ-022 Input priority within a cycle SHALL be clr > enter > prog > digit_vld; any lower-priority strobe arriving in the same cycle SHALL be ignored.
REQ-023 In IDLE, a digit_vld SHALL write the buffer at index 0, set cnt=1 and move to ENTRY; an enter with cnt=0 SHALL be ignored.
REQ-024 In ENTRY, each digit_vld SHALL append at index cnt; when cnt=CODE_LEN it SHALL instead set ovf=1 and discard the digit.
REQ-025 In ENTRY, an enter SHALL move to CHECK; the result SHALL be registered one cycle later, so open or alarm is visible 2 cycles after enter is sampled.
REQ-026 A match SHALL require cnt==CODE_LEN, ovf==0 and buffer==code; short or over-long entries SHALL count as failures.
REQ-027 On a match: open=1, alarm=0, fail_cnt=0, state OPEN.
REQ-028 On a mismatch: alarm=1 and fail_cnt saturates at MAX_FAIL.
REQ-029 After a mismatch, if fail_cnt reaches MAX_FAIL the state SHALL be LOCKOUT with lockout=1; otherwise it SHALL be IDLE.
REQ-030 cnt and ovf SHALL be cleared on every exit from CHECK.
REQ-031 In ENTRY, clr SHALL clear cnt and ovf and return to IDLE; it SHALL NOT count as a failure and SHALL leave alarm unchanged.
REQ-032 ENTRY_TO consecutive cycles in ENTRY without a digit_vld SHALL behave as clr.
REQ-033 OPEN SHALL last OPEN_CYC cycles, then open=0 and the state returns to IDLE; enter in OPEN SHALL relock immediately on the next cycle.
REQ-034 In OPEN, digit_vld SHALL fill the buffer as in ENTRY.
REQ-035 In OPEN, prog with cnt==CODE_LEN and ovf==0 SHALL load code from the buffer, pulse code_upd for 1 cycle, clear cnt and leave open asserted; an invalid prog SHALL only clear cnt.
REQ-036 In LOCKOUT, all strobes including clr SHALL be ignored for LOCKOUT_CYC cycles.
REQ-037 On LOCKOUT expiry: lockout=0, alarm=0, fail_cnt=0, state IDLE.
REQ-038 All timers SHALL count from 0 to N-1 with no wrap-around or re-trigger while their state is active.

Reset
REQ-039 While rst=1, regardless of the current state: state=IDLE, code=INIT_CODE, buffer=0, cnt=0, ovf=0, all timers=0, open=0, alarm=0, lockout=0, fail_cnt=0, code_upd=0, led1=1, led2=1.
REQ-040 Any stored reprogrammed code SHALL be lost on reset.

Verification (OPEN_CYC=8, LOCKOUT_CYC=16, ENTRY_TO=32, defaults otherwise)
REQ-041 Digits 1,2,3,4 then enter -> open=1 and led1=0 2 cycles after enter; open falls after 8 cycles; fail_cnt=0.
REQ-042 Digits 1,2,3,5 then enter, three times -> fail_cnt steps 1, 2, 3; alarm=1; after the third attempt lockout=1 for 16 cycles with correct code 1,2,3,4 ignored; then lockout=0, alarm=0, fail_cnt=0.
REQ-043 Digits 1,2,3 then enter -> fail (short entry); digits 1,2,3,4,4 then enter -> fail (ovf).
REQ-044 Digits 1,2 then clr, and separately digits 1,2 then a 32-cycle gap -> IDLE, fail_cnt unchanged; next 1,2,3,4 then enter opens.
REQ-045 Open with 1,2,3,4, then digits 9,8,7,6 and prog -> code_upd pulses; after relock 1,2,3,4 fails and 9,8,7,6 opens; then rst -> 1,2,3,4 opens again.
REQ-046 digit_vld and enter in the same cycle -> digit ignored; rst asserted mid-OPEN -> open=0 immediately (asynchronous).

Source files
------------

// File: rtl/coded_lock_seq.sv
// coded_lock_seq: digit-entry combination lock with failure lockout, timed unlock
// and in-field code reprogramming.
module coded_lock_seq #(
    parameter int                              DIGIT_W     = 4,
    parameter int                              CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]     INIT_CODE   = 16'h1234,
    parameter int                              MAX_FAIL    = 3,
    parameter int                              OPEN_CYC    = 500,
    parameter int                              LOCKOUT_CYC = 1000,
    parameter int                              ENTRY_TO    = 2000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               digit_vld,
    input  logic                               enter,
    input  logic                               clr,
    input  logic                               prog,
    output logic                               open,
    output logic                               alarm,
    output logic                               lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt,
    output logic                               code_upd,
    output logic                               led1,
    output logic                               led2
);
    localparam int CW   = DIGIT_W * CODE_LEN;
    localparam int NW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int T1   = OPEN_CYC > LOCKOUT_CYC ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMAX = T1 > ENTRY_TO ? T1 : ENTRY_TO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] code, code_n;
    logic [CW-1:0] entry_buf, entry_buf_n;
    logic [NW-1:0] cnt, cnt_n;
    logic          ovf, ovf_n;
    logic [TW-1:0] timer, timer_n;
    logic          open_n, alarm_n, lockout_n, code_upd_n;
    logic [FW-1:0] fail_n, fail_inc;
    logic          app, full, match;

    assign full     = cnt == NW'(CODE_LEN);
    assign match    = full && !ovf && entry_buf == code;
    assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
    assign led1     = ~open;
    assign led2     = ~alarm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code      <= INIT_CODE;
            entry_buf <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            timer     <= '0;
            open      <= 1'b0;
            alarm     <= 1'b0;
            lockout   <= 1'b0;
            fail_cnt  <= '0;
            code_upd  <= 1'b0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            entry_buf <= entry_buf_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            timer     <= timer_n;
            open      <= open_n;
            alarm     <= alarm_n;
            lockout   <= lockout_n;
            fail_cnt  <= fail_n;
            code_upd  <= code_upd_n;
        end
    end

    always_comb begin
        state_n     = state;
        code_n      = code;
        entry_buf_n = entry_buf;
        cnt_n       = cnt;
        ovf_n       = ovf;
        timer_n     = timer;
        open_n      = open;
        alarm_n     = alarm;
        lockout_n   = lockout;
        fail_n      = fail_cnt;
        code_upd_n  = 1'b0;
        app         = 1'b0;
        case (state)
            IDLE: begin
                if (!clr && !enter && !prog && digit_vld) begin
                    entry_buf_n[CW-1 -: DIGIT_W] = digit;
                    cnt_n   = NW'(1);
                    timer_n = '0;
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (clr) begin
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    timer_n = '0;
                    state_n = IDLE;
                end else if (enter) begin
                    timer_n = '0;
                    state_n = CHECK;
                end else if (!prog && digit_vld) begin
                    app     = 1'b1;
                    timer_n = '0;
                end else if (timer == TW'(ENTRY_TO - 1)) begin
                    // entry went idle too long: drop it exactly like clr
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            CHECK: begin
                cnt_n   = '0;
                ovf_n   = 1'b0;
                timer_n = '0;
                if (match) begin
                    open_n  = 1'b1;
                    alarm_n = 1'b0;
                    fail_n  = '0;
                    state_n = OPEN;
                end else begin
                    alarm_n = 1'b1;
                    fail_n  = fail_inc;
                    if (fail_inc == FW'(MAX_FAIL)) begin
                        lockout_n = 1'b1;
                        state_n   = LOCKOUT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            OPEN: begin
                if (timer == TW'(OPEN_CYC - 1) || (!clr && enter)) begin
                    open_n  = 1'b0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                    if (clr) begin
                        cnt_n = '0;
                        ovf_n = 1'b0;
                    end else if (prog) begin
                        cnt_n = '0;
                        if (full && !ovf) begin
                            code_n     = entry_buf;
                            code_upd_n = 1'b1;
                        end
                    end else if (digit_vld) begin
                        app = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                if (timer == TW'(LOCKOUT_CYC - 1)) begin
                    lockout_n = 1'b0;
                    alarm_n   = 1'b0;
                    fail_n    = '0;
                    timer_n   = '0;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // shared digit append for ENTRY and OPEN; a digit past the end flags overflow
        if (app) begin
            if (full) begin
                ovf_n = 1'b1;
            end else begin
                entry_buf_n[CW - DIGIT_W * (int'(cnt) + 1) +: DIGIT_W] = digit;
                cnt_n = cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_coded_lock_seq.sv
// tb_coded_lock_seq: scoreboard bench; a queue-based model of the lock rules
// predicts timed output snapshots that a separate monitor compares each cycle.
module tb_coded_lock_seq;
    localparam int OC = 8, LC = 16, ET = 32, MAXF = 3;

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] digit = '0;
    logic       digit_vld = 1'b0, enter = 1'b0, clr = 1'b0, prog = 1'b0;
    logic       open, alarm, lockout, code_upd, led1, led2;
    logic [1:0] fail_cnt;

    coded_lock_seq #(.OPEN_CYC(OC), .LOCKOUT_CYC(LC), .ENTRY_TO(ET)) dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_vld(digit_vld), .enter(enter),
        .clr(clr), .prog(prog), .open(open), .alarm(alarm), .lockout(lockout),
        .fail_cnt(fail_cnt), .code_upd(code_upd), .led1(led1), .led2(led2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit o, a, l, u;
        int f;
    } snap_t;

    snap_t sb[$];
    int    cyc = 0, checks = 0, errors = 0;
    int    mcode[$];
    int    fails = 0;
    bit    malarm = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void expect_at(input int c, input bit o, input bit a, input bit l,
                                      input int f, input bit u);
        snap_t s;
        s.cyc = c; s.o = o; s.a = a; s.l = l; s.f = f; s.u = u;
        sb.push_back(s);
    endfunction

    function automatic bit same(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        snap_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_snapshot", cyc, e.cyc);
        end
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("open", int'(open), int'(e.o));
            chk("alarm", int'(alarm), int'(e.a));
            chk("lockout", int'(lockout), int'(e.l));
            chk("fail_cnt", int'(fail_cnt), e.f);
            chk("code_upd", int'(code_upd), int'(e.u));
            chk("led1", int'(led1), int'(!e.o));
            chk("led2", int'(led2), int'(!e.a));
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ds[$], input int gap);
        foreach (ds[i]) begin
            digit = 4'(ds[i]);
            digit_vld = 1'b1;
            step(1);
            digit_vld = 1'b0;
            step(gap);
        end
    endtask

    task automatic submit(input int ds[$], input int gap, input int extra,
                          output bit hit, output bit lk, output int n);
        send(ds, gap);
        n = cyc;
        enter = 1'b1;
        if (extra >= 0) begin
            digit = 4'(extra);
            digit_vld = 1'b1;
        end
        step(1);
        enter = 1'b0;
        digit_vld = 1'b0;
        hit = same(ds, mcode);
        lk = 1'b0;
        if (hit) begin
            fails = 0;
            malarm = 1'b0;
            expect_at(n + 2, 1, 0, 0, 0, 0);
        end else begin
            fails = fails < MAXF ? fails + 1 : MAXF;
            malarm = 1'b1;
            lk = fails == MAXF;
            expect_at(n + 2, 0, 1, lk, fails, 0);
        end
        step(1);
    endtask

    task automatic finish_open(input int n, input bit relock);
        if (relock) begin
            enter = 1'b1;
            step(1);
            enter = 1'b0;
            expect_at(cyc, 0, 0, 0, 0, 0);
        end else begin
            expect_at(n + 2 + OC - 1, 1, 0, 0, 0, 0);
            expect_at(n + 2 + OC, 0, 0, 0, 0, 0);
            while (cyc < n + 2 + OC) step(1);
        end
    endtask

    task automatic wait_lockout(input int n, input bit probe);
        if (probe) begin
            send('{1, 2, 3, 4}, 0);
            enter = 1'b1;
            step(1);
            enter = 1'b0;
            clr = 1'b1;
            step(1);
            clr = 1'b0;
            expect_at(cyc, 0, 1, 1, MAXF, 0);
        end
        expect_at(n + 2 + LC - 1, 0, 1, 1, MAXF, 0);
        expect_at(n + 2 + LC, 0, 0, 0, 0, 0);
        fails = 0;
        malarm = 1'b0;
        while (cyc < n + 2 + LC) step(1);
    endtask

    task automatic clr_now();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        expect_at(cyc, 0, malarm, 0, fails, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc %0d got running expected finished", cyc);
        $fatal(1);
    end

    initial begin
        bit hit, lk;
        int n, m;
        int ds[$];
        mcode = '{1, 2, 3, 4};
        step(3);
        expect_at(cyc, 0, 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        step(1);
        expect_at(cyc, 0, 0, 0, 0, 0);
        step(1);

        // correct code opens, then times out
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        finish_open(n, 1'b0);

        // three bad attempts lead to lockout that ignores the right code
        submit('{1, 2, 3, 5}, 0, -1, hit, lk, n);
        submit('{1, 2, 3, 5}, 1, -1, hit, lk, n);
        submit('{1, 2, 3, 5}, 0, -1, hit, lk, n);
        if (lk) wait_lockout(n, 1'b1);
        else chk("lockout_model", 0, 1);

        // short and over-long entries fail; clr keeps the failure count
        submit('{1, 2, 3}, 0, -1, hit, lk, n);
        submit('{1, 2, 3, 4, 4}, 0, -1, hit, lk, n);
        send('{1, 2}, 0);
        clr_now();
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        finish_open(n, 1'b1);

        // idle entry times out like clr
        submit('{1, 2, 3, 5}, 0, -1, hit, lk, n);
        send('{1, 2}, 0);
        step(ET + 8);
        expect_at(cyc + 1, 0, 1, 0, 1, 0);
        step(1);
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        finish_open(n, 1'b1);

        // digit coincident with enter is dropped
        submit('{1, 2, 3}, 0, 4, hit, lk, n);
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        finish_open(n, 1'b1);

        // reprogram while open, relock, verify new code, then reset restores old
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        send('{9, 8, 7, 6}, 0);
        m = cyc;
        prog = 1'b1;
        step(1);
        prog = 1'b0;
        expect_at(m + 1, 1, 0, 0, 0, 1);
        enter = 1'b1;
        step(1);
        enter = 1'b0;
        expect_at(m + 2, 0, 0, 0, 0, 0);
        mcode = '{9, 8, 7, 6};
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        submit('{9, 8, 7, 6}, 0, -1, hit, lk, n);
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_open", int'(open), 0);
        chk("async_rst_led1", int'(led1), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcode = '{1, 2, 3, 4};
        fails = 0;
        malarm = 1'b0;
        step(1);
        submit('{1, 2, 3, 4}, 0, -1, hit, lk, n);
        finish_open(n, 1'b0);

        // randomized attempts against the model
        for (int i = 0; i < 40; i++) begin
            int kind, len, idx;
            if ($urandom_range(0, 3) == 0) begin
                ds = {};
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) ds.push_back($urandom_range(0, 15));
                send(ds, $urandom_range(0, 2));
                clr_now();
            end
            kind = $urandom_range(0, 3);
            ds = mcode;
            if (kind == 1) begin
                ds = {};
                len = $urandom_range(2, 6);
                for (int j = 0; j < len; j++) ds.push_back($urandom_range(0, 15));
            end else if (kind == 2) begin
                idx = $urandom_range(0, 3);
                ds[idx] = (ds[idx] + 1 + $urandom_range(0, 14)) % 16;
            end else if (kind == 3) begin
                if ($urandom_range(0, 1) == 1) ds.push_back($urandom_range(0, 15));
                else void'(ds.pop_back());
            end
            submit(ds, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1,
                   hit, lk, n);
            if (hit) finish_open(n, 1'($urandom_range(0, 1)));
            else if (lk) wait_lockout(n, 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 100 && sb.size() > 0; k++) step(1);
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
